// File: rtl/reg_cmd_ctrl.sv
// reg_cmd_ctrl: turns a received byte stream into RegFile write/read transactions
// and returns each read result as a single byte on the transmitter port.
// Commands: WR_CMD, addr, data  -> one RF_WrEn strobe
//           RD_CMD, addr        -> one RF_RdEn strobe, then read byte to TX
// Optional feature macro: RD_TIMEOUT_EN (read-wait timeout with error byte).
//
// state   | meaning
// IDLE    | waiting for a command byte
// WR_ADDR | write command seen, waiting for address byte
// WR_DATA | write address held, waiting for data byte
// RD_ADDR | read command seen, waiting for address byte
// RD_WAIT | read strobe issued, waiting for RegFile read data
// TX_SEND | read byte captured, waiting for transmitter to be free
module reg_cmd_ctrl #(
  parameter int unsigned               DATA_WIDTH     = 8,
  parameter int unsigned               ADDRESS_WIDTH  = 4,
  parameter logic [DATA_WIDTH-1:0]     WR_CMD         = 8'hAA,
  parameter logic [DATA_WIDTH-1:0]     RD_CMD         = 8'hBB,
  parameter int unsigned               TIMEOUT_CYCLES = 16,
  parameter logic [DATA_WIDTH-1:0]     RD_ERR_BYTE    = 8'hEE
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  output logic                     RF_WrEn,
  output logic                     RF_RdEn,
  output logic [ADDRESS_WIDTH-1:0] RF_Address,
  output logic [DATA_WIDTH-1:0]    RF_WrData,
  input  logic [DATA_WIDTH-1:0]    RF_RdData,
  input  logic                     RF_RdData_Valid,
  output logic [DATA_WIDTH-1:0]    TX_P_DATA,
  output logic                     TX_D_VLD,
  input  logic                     TX_BUSY,
  output logic                     CMD_ERR
);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND
  } state_t;

  state_t                   state_q, state_d;
  logic                     wr_en_q, wr_en_d;
  logic                     rd_en_q, rd_en_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRESS_WIDTH-1:0] addr_pend_q, addr_pend_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    rbyte_q, rbyte_d;
  logic [DATA_WIDTH-1:0]    tx_data_q, tx_data_d;
  logic                     tx_vld_q, tx_vld_d;
  logic                     err_q, err_d;

  // Upper address-byte bits are deliberately ignored.
  logic unused_rx_hi;
  assign unused_rx_hi = ^RX_P_DATA[DATA_WIDTH-1:ADDRESS_WIDTH];

`ifdef RD_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_expire;
  assign rd_expire = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic [DATA_WIDTH-1:0] unused_cfg;
  assign unused_cfg = RD_ERR_BYTE ^ DATA_WIDTH'(TIMEOUT_CYCLES);
`endif

  // Next-state and registered-output computation; strobes default low.
  always_comb begin
    state_d     = state_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    tx_vld_d    = 1'b0;
    err_d       = 1'b0;
    addr_d      = addr_q;
    addr_pend_d = addr_pend_q;
    wdata_d     = wdata_q;
    rbyte_d     = rbyte_q;
    tx_data_d   = tx_data_q;
`ifdef RD_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == WR_CMD)      state_d = WR_ADDR;
          else if (RX_P_DATA == RD_CMD) state_d = RD_ADDR;
          else                          err_d   = 1'b1;
        end
      end
      WR_ADDR: begin
        // Held aside so RF_Address only changes together with a strobe.
        if (RX_D_VLD) begin
          addr_pend_d = RX_P_DATA[ADDRESS_WIDTH-1:0];
          state_d     = WR_DATA;
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          addr_d  = addr_pend_q;
          wdata_d = RX_P_DATA;
          wr_en_d = 1'b1;
          state_d = IDLE;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDRESS_WIDTH-1:0];
          rd_en_d = 1'b1;
          state_d = RD_WAIT;
`ifdef RD_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      RD_WAIT: begin
        err_d = RX_D_VLD;
        if (RF_RdData_Valid) begin
          // Forward straight to TX when free to keep valid->TX latency at one cycle.
          if (!TX_BUSY) begin
            tx_data_d = RF_RdData;
            tx_vld_d  = 1'b1;
            state_d   = IDLE;
          end else begin
            rbyte_d = RF_RdData;
            state_d = TX_SEND;
          end
        end
`ifdef RD_TIMEOUT_EN
        else if (rd_expire) begin
          rbyte_d = RD_ERR_BYTE;
          err_d   = 1'b1;
          state_d = TX_SEND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      TX_SEND: begin
        err_d = RX_D_VLD;
        if (!TX_BUSY) begin
          tx_data_d = rbyte_q;
          tx_vld_d  = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      addr_pend_q <= '0;
      wdata_q     <= '0;
      rbyte_q     <= '0;
      tx_data_q   <= '0;
      tx_vld_q    <= 1'b0;
      err_q       <= 1'b0;
`ifdef RD_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      addr_pend_q <= addr_pend_d;
      wdata_q     <= wdata_d;
      rbyte_q     <= rbyte_d;
      tx_data_q   <= tx_data_d;
      tx_vld_q    <= tx_vld_d;
      err_q       <= err_d;
`ifdef RD_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign RF_WrEn    = wr_en_q;
  assign RF_RdEn    = rd_en_q;
  assign RF_Address = addr_q;
  assign RF_WrData  = wdata_q;
  assign TX_P_DATA  = tx_data_q;
  assign TX_D_VLD   = tx_vld_q;
  assign CMD_ERR    = err_q;

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Directed bench for reg_cmd_ctrl; the RegFile read side is driven by the tasks.
module tb_reg_cmd_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] RX_P_DATA;
  logic       RX_D_VLD;
  logic       RF_WrEn;
  logic       RF_RdEn;
  logic [3:0] RF_Address;
  logic [7:0] RF_WrData;
  logic [7:0] RF_RdData;
  logic       RF_RdData_Valid;
  logic [7:0] TX_P_DATA;
  logic       TX_D_VLD;
  logic       TX_BUSY;
  logic       CMD_ERR;

  int checks   = 0;
  int failures = 0;

  int wr_cnt  = 0;
  int rd_cnt  = 0;
  int tx_cnt  = 0;
  int err_cnt = 0;
  int both_hi = 0;

  reg_cmd_ctrl dut (
    .CLK            (CLK),
    .RST            (RST),
    .RX_P_DATA      (RX_P_DATA),
    .RX_D_VLD       (RX_D_VLD),
    .RF_WrEn        (RF_WrEn),
    .RF_RdEn        (RF_RdEn),
    .RF_Address     (RF_Address),
    .RF_WrData      (RF_WrData),
    .RF_RdData      (RF_RdData),
    .RF_RdData_Valid(RF_RdData_Valid),
    .TX_P_DATA      (TX_P_DATA),
    .TX_D_VLD       (TX_D_VLD),
    .TX_BUSY        (TX_BUSY),
    .CMD_ERR        (CMD_ERR)
  );

  always #5 CLK = ~CLK;

  // Strobe counters sampled mid-cycle.
  always @(negedge CLK) begin
    if (RF_WrEn === 1'b1) wr_cnt++;
    if (RF_RdEn === 1'b1) rd_cnt++;
    if (TX_D_VLD === 1'b1) tx_cnt++;
    if (CMD_ERR === 1'b1) err_cnt++;
    if (RF_WrEn === 1'b1 && RF_RdEn === 1'b1) both_hi++;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    step();
    RX_D_VLD  = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    RX_P_DATA = 8'hAA;
    RX_D_VLD = 1'b1;
    RF_RdData = 8'h00;
    RF_RdData_Valid = 1'b0;
    TX_BUSY = 1'b0;
    step();
    RX_P_DATA = 8'hBB;
    step();
    checks++;
    if ({RF_WrEn, RF_RdEn, TX_D_VLD, CMD_ERR} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_strobes got=%b want=0000", {RF_WrEn, RF_RdEn, TX_D_VLD, CMD_ERR});
    end
    checks++;
    if ({RF_Address, RF_WrData, TX_P_DATA} !== 20'h0) begin
      failures++;
      $display("FAIL reset_data got=%h want=00000", {RF_Address, RF_WrData, TX_P_DATA});
    end
    RX_D_VLD = 1'b0;
    RST = 1'b0;
    step();
    step();
    checks++;
    if (wr_cnt + rd_cnt + tx_cnt + err_cnt !== 0) begin
      failures++;
      $display("FAIL reset_ignore_rx got=%0d strobes want=0", wr_cnt + rd_cnt + tx_cnt + err_cnt);
    end
  endtask

  task automatic test_write();
    int w0, t0;
    w0 = wr_cnt; t0 = tx_cnt;
    send(8'hAA);
    send(8'h03);
    checks++;
    if (RF_WrEn !== 1'b0) begin
      failures++;
      $display("FAIL write_early got=%b want=0", RF_WrEn);
    end
    send(8'h5C);
    checks++;
    if ({RF_WrEn, RF_Address, RF_WrData} !== {1'b1, 4'h3, 8'h5C}) begin
      failures++;
      $display("FAIL write_strobe got=%b/%h/%h want=1/3/5c", RF_WrEn, RF_Address, RF_WrData);
    end
    step();
    checks++;
    if ({RF_WrEn, RF_Address, RF_WrData} !== {1'b0, 4'h3, 8'h5C}) begin
      failures++;
      $display("FAIL write_hold got=%b/%h/%h want=0/3/5c", RF_WrEn, RF_Address, RF_WrData);
    end
    step();
    checks++;
    if (wr_cnt - w0 !== 1 || tx_cnt - t0 !== 0) begin
      failures++;
      $display("FAIL write_counts got wr=%0d tx=%0d want wr=1 tx=0", wr_cnt - w0, tx_cnt - t0);
    end
  endtask

  task automatic test_read();
    int r0;
    r0 = rd_cnt;
    send(8'hBB);
    send(8'h02);
    checks++;
    if ({RF_RdEn, RF_WrEn, RF_Address} !== {1'b1, 1'b0, 4'h2}) begin
      failures++;
      $display("FAIL read_strobe got=%b/%b/%h want=1/0/2", RF_RdEn, RF_WrEn, RF_Address);
    end
    step();
    RF_RdData = 8'hFF;
    RF_RdData_Valid = 1'b1;
    step();
    RF_RdData_Valid = 1'b0;
    checks++;
    if ({TX_D_VLD, TX_P_DATA} !== {1'b1, 8'hFF}) begin
      failures++;
      $display("FAIL read_tx got=%b/%h want=1/ff", TX_D_VLD, TX_P_DATA);
    end
    step();
    checks++;
    if ({TX_D_VLD, TX_P_DATA} !== {1'b0, 8'hFF}) begin
      failures++;
      $display("FAIL read_tx_hold got=%b/%h want=0/ff", TX_D_VLD, TX_P_DATA);
    end
    checks++;
    if (rd_cnt - r0 !== 1) begin
      failures++;
      $display("FAIL read_rden_count got=%0d want=1", rd_cnt - r0);
    end
  endtask

  task automatic test_busy();
    int w0, r0;
    bit early;
    w0 = wr_cnt; r0 = rd_cnt;
    early = 1'b0;
    TX_BUSY = 1'b1;
    send(8'hBB);
    send(8'h05);
    send(8'h11);
    checks++;
    if (CMD_ERR !== 1'b1) begin
      failures++;
      $display("FAIL busy_drop_err got=%b want=1", CMD_ERR);
    end
    RF_RdData = 8'h3C;
    RF_RdData_Valid = 1'b1;
    step();
    RF_RdData_Valid = 1'b0;
    if (TX_D_VLD !== 1'b0) early = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (TX_D_VLD !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early) begin
      failures++;
      $display("FAIL busy_hold got=early TX_D_VLD want=none");
    end
    checks++;
    if (TX_P_DATA !== 8'hFF) begin
      failures++;
      $display("FAIL busy_tx_data_hold got=%h want=ff", TX_P_DATA);
    end
    TX_BUSY = 1'b0;
    step();
    checks++;
    if ({TX_D_VLD, TX_P_DATA} !== {1'b1, 8'h3C}) begin
      failures++;
      $display("FAIL busy_release got=%b/%h want=1/3c", TX_D_VLD, TX_P_DATA);
    end
    step();
    checks++;
    if (wr_cnt - w0 !== 0 || rd_cnt - r0 !== 1) begin
      failures++;
      $display("FAIL busy_no_effect got wr=%0d rd=%0d want wr=0 rd=1", wr_cnt - w0, rd_cnt - r0);
    end
  endtask

  task automatic test_errors();
    int w0;
    send(8'h42);
    checks++;
    if (CMD_ERR !== 1'b1) begin
      failures++;
      $display("FAIL err_unknown got=%b want=1", CMD_ERR);
    end
    step();
    checks++;
    if (CMD_ERR !== 1'b0) begin
      failures++;
      $display("FAIL err_pulse_width got=%b want=0", CMD_ERR);
    end
    w0 = wr_cnt;
    send(8'hAA);
    send(8'h01);
    RST = 1'b1;
    step();
    RST = 1'b0;
    checks++;
    if (RF_Address !== 4'h0) begin
      failures++;
      $display("FAIL err_rst_addr got=%h want=0", RF_Address);
    end
    send(8'h5C);
    step();
    step();
    checks++;
    if (wr_cnt - w0 !== 0) begin
      failures++;
      $display("FAIL err_rst_abort got=%0d writes want=0", wr_cnt - w0);
    end
    send(8'hAA);
    send(8'hF7);
    send(8'h99);
    checks++;
    if ({RF_WrEn, RF_Address, RF_WrData} !== {1'b1, 4'h7, 8'h99}) begin
      failures++;
      $display("FAIL err_addr_trunc got=%b/%h/%h want=1/7/99", RF_WrEn, RF_Address, RF_WrData);
    end
  endtask

  task automatic test_back_to_back();
    send(8'hAA);
    send(8'h04);
    send(8'h12);
    checks++;
    if ({RF_WrEn, RF_Address, RF_WrData} !== {1'b1, 4'h4, 8'h12}) begin
      failures++;
      $display("FAIL b2b_write got=%b/%h/%h want=1/4/12", RF_WrEn, RF_Address, RF_WrData);
    end
    send(8'hBB);
    send(8'h09);
    checks++;
    if ({RF_RdEn, RF_Address} !== {1'b1, 4'h9}) begin
      failures++;
      $display("FAIL b2b_read got=%b/%h want=1/9", RF_RdEn, RF_Address);
    end
    RF_RdData = 8'h12;
    RF_RdData_Valid = 1'b1;
    step();
    RF_RdData_Valid = 1'b0;
    checks++;
    if ({TX_D_VLD, TX_P_DATA} !== {1'b1, 8'h12}) begin
      failures++;
      $display("FAIL b2b_tx got=%b/%h want=1/12", TX_D_VLD, TX_P_DATA);
    end
    step();
    checks++;
    if (both_hi !== 0) begin
      failures++;
      $display("FAIL both_strobes got=%0d want=0", both_hi);
    end
  endtask

`ifdef RD_TIMEOUT_EN
  task automatic test_rd_wait();
    int err_at, tx_at;
    err_at = -1; tx_at = -1;
    send(8'hBB);
    send(8'h01);
    for (int i = 1; i <= 40 && tx_at < 0; i++) begin
      step();
      if (CMD_ERR === 1'b1 && err_at < 0) err_at = i;
      if (TX_D_VLD === 1'b1) tx_at = i;
    end
    checks++;
    if (err_at !== 16) begin
      failures++;
      $display("FAIL timeout_err_cycle got=%0d want=16", err_at);
    end
    checks++;
    if (tx_at !== 17 || TX_P_DATA !== 8'hEE) begin
      failures++;
      $display("FAIL timeout_tx got cycle=%0d data=%h want cycle=17 data=ee", tx_at, TX_P_DATA);
    end
    step();
  endtask
`else
  task automatic test_rd_wait();
    int t0, e0;
    send(8'hBB);
    send(8'h06);
    t0 = tx_cnt; e0 = err_cnt;
    for (int i = 0; i < 40; i++) step();
    checks++;
    if (tx_cnt - t0 !== 0 || err_cnt - e0 !== 0) begin
      failures++;
      $display("FAIL wait_forever got tx=%0d err=%0d want 0/0", tx_cnt - t0, err_cnt - e0);
    end
    RF_RdData = 8'h77;
    RF_RdData_Valid = 1'b1;
    step();
    RF_RdData_Valid = 1'b0;
    checks++;
    if ({TX_D_VLD, TX_P_DATA} !== {1'b1, 8'h77}) begin
      failures++;
      $display("FAIL wait_late_data got=%b/%h want=1/77", TX_D_VLD, TX_P_DATA);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_busy();
    test_errors();
    test_back_to_back();
    test_rd_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
